// File: rtl/mcycle_seq.sv
// Machine-cycle / T-state sequencer for the 8085 core: runs the M1 fetch, then the
// extra read/write/I-O/idle cycles flagged by the decoder, and drives the bus strobes.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   TS_IDLE | out of reset (mcyc=0) or halted
//   TS_T1   | address phase, ale high on bus cycles
//   TS_T2   | strobe asserted, ready sampled
//   TS_TW   | wait state, strobe held, ready sampled
//   TS_T3   | strobe asserted, data latched
//   TS_T4   | M1 decode, shadow of chk_inst valid
//   TS_T5   | M1 extension (GO6)
//   TS_T6   | M1 extension (GO6)
module mcycle_seq #(
    parameter int INSTSIZE = 13,
    parameter int INFO_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTSIZE-1:0] chk_inst,
    input  logic                cnd_chk,
    input  logic                ready,
    output logic                enb_code,
    output logic                enb_data,
    output logic                enb_rreg,
    output logic                enb_wreg,
    output logic                ale,
    output logic                rd_n,
    output logic                wr_n,
    output logic                iom,
    output logic                s1,
    output logic                s0,
    output logic [2:0]          mcyc,
    output logic [2:0]          tstate,
    output logic                halted
);

    localparam int B_GO6   = 0;
    localparam int B_DAD   = 1;
    localparam int B_HLT   = 2;
    localparam int B_DIO   = 3;
    localparam int B_CYCGO = 4;
    localparam int B_CYCRW = 4 + INFO_CYC;
    localparam int B_CCC   = 4 + 2 * INFO_CYC;

    typedef enum logic [2:0] {
        TS_IDLE = 3'd0,
        TS_T1   = 3'd1,
        TS_T2   = 3'd2,
        TS_T3   = 3'd3,
        TS_T4   = 3'd4,
        TS_T5   = 3'd5,
        TS_T6   = 3'd6,
        TS_TW   = 3'd7
    } tstate_t;

    typedef struct packed {
        logic                go6;
        logic                dad;
        logic                hlt;
        logic                dio;
        logic                nowb;
        logic [INFO_CYC-1:0] cycgo;
        logic [INFO_CYC-1:0] cycrw;
    } shadow_t;

    tstate_t     r_ts;
    logic [2:0]  r_mcyc;
    logic        r_halt;
    logic        r_rdterm;
    shadow_t     r_sh;

    tstate_t     w_ts_n;
    logic [2:0]  w_mcyc_n;
    logic        w_halt_n;
    logic        w_rdterm_n;
    shadow_t     w_sh_n;
    shadow_t     w_sh_cap;

    logic [1:0]  w_kidx;
    logic [1:0]  w_kidx_nxt;
    logic        w_idle;
    logic        w_wr;
    logic        w_more;
    logic [2:0]  w_m1_exit;

    logic [1:0]  w_kidx_n;
    logic        w_idle_n;
    logic        w_wr_n;
    logic        w_stb_n;
    logic        w_m1_wb_n;

    logic        w_o_ale, w_o_rd_n, w_o_wr_n, w_o_iom;
    logic [1:0]  w_o_s;
    logic        w_o_code, w_o_data, w_o_rreg, w_o_wreg;

    logic        r_ale, r_rd_n, r_wr_n, r_iom;
    logic [1:0]  r_s;
    logic        r_code, r_data, r_rreg, r_wreg;

    // A not-taken conditional return behaves as a one-cycle instruction with no writeback.
    always_comb begin
        w_sh_cap.go6   = chk_inst[B_GO6];
        w_sh_cap.dad   = chk_inst[B_DAD];
        w_sh_cap.hlt   = chk_inst[B_HLT];
        w_sh_cap.dio   = chk_inst[B_DIO];
        w_sh_cap.nowb  = cnd_chk & ~chk_inst[B_CCC];
        w_sh_cap.cycgo = w_sh_cap.nowb ? '0 : chk_inst[B_CYCGO +: INFO_CYC];
        w_sh_cap.cycrw = chk_inst[B_CYCRW +: INFO_CYC];
    end

    assign w_kidx     = r_mcyc[1:0] - 2'd2;
    assign w_kidx_nxt = r_mcyc[1:0] - 2'd1;
    assign w_idle     = ((r_mcyc == 3'd2) && r_sh.hlt) ||
                        (r_sh.dad && ((r_mcyc == 3'd2) || (r_mcyc == 3'd3)));
    assign w_wr       = r_sh.cycrw[w_kidx];
    assign w_more     = (r_mcyc != 3'd5) && r_sh.cycgo[w_kidx_nxt];
    assign w_m1_exit  = (r_sh.hlt || r_sh.cycgo[0]) ? 3'd2 : 3'd1;

    always_comb begin
        w_ts_n     = r_ts;
        w_mcyc_n   = r_mcyc;
        w_halt_n   = r_halt;
        w_sh_n     = r_sh;
        w_rdterm_n = 1'b0;
        case (r_ts)
            TS_IDLE: begin
                if (!r_halt) begin
                    w_ts_n   = TS_T1;
                    w_mcyc_n = 3'd1;
                end
            end
            TS_T1: w_ts_n = TS_T2;
            TS_T2, TS_TW: begin
                if (w_idle || ready) w_ts_n = TS_T3;
                else                 w_ts_n = TS_TW;
            end
            TS_T3: begin
                if (r_mcyc == 3'd1) begin
                    w_ts_n = TS_T4;
                    w_sh_n = w_sh_cap;
                end else if ((r_mcyc == 3'd2) && r_sh.hlt) begin
                    w_ts_n   = TS_IDLE;
                    w_mcyc_n = 3'd0;
                    w_halt_n = 1'b1;
                end else begin
                    w_ts_n = TS_T1;
                    if (w_more) begin
                        w_mcyc_n = r_mcyc + 3'd1;
                    end else begin
                        w_mcyc_n   = 3'd1;
                        w_rdterm_n = !w_wr && !w_idle;
                    end
                end
            end
            TS_T4: begin
                if (r_sh.go6) begin
                    w_ts_n = TS_T5;
                end else begin
                    w_ts_n   = TS_T1;
                    w_mcyc_n = w_m1_exit;
                end
            end
            TS_T5: w_ts_n = TS_T6;
            TS_T6: begin
                w_ts_n   = TS_T1;
                w_mcyc_n = w_m1_exit;
            end
            default: w_ts_n = TS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts     <= TS_IDLE;
            r_mcyc   <= 3'd0;
            r_halt   <= 1'b0;
            r_rdterm <= 1'b0;
            r_sh     <= '0;
        end else begin
            r_ts     <= w_ts_n;
            r_mcyc   <= w_mcyc_n;
            r_halt   <= w_halt_n;
            r_rdterm <= w_rdterm_n;
            r_sh     <= w_sh_n;
        end
    end

    // Bus outputs are decoded from the next state and registered alongside it.
    assign w_kidx_n  = w_mcyc_n[1:0] - 2'd2;
    assign w_idle_n  = ((w_mcyc_n == 3'd2) && w_sh_n.hlt) ||
                       (w_sh_n.dad && ((w_mcyc_n == 3'd2) || (w_mcyc_n == 3'd3)));
    assign w_wr_n    = w_sh_n.cycrw[w_kidx_n];
    assign w_stb_n   = (w_ts_n == TS_T2) || (w_ts_n == TS_T3) || (w_ts_n == TS_TW);
    assign w_m1_wb_n = !w_sh_n.cycgo[0] && !w_sh_n.nowb && !w_sh_n.hlt;

    always_comb begin
        w_o_ale  = 1'b0;
        w_o_rd_n = 1'b1;
        w_o_wr_n = 1'b1;
        w_o_iom  = 1'b0;
        w_o_s    = 2'b00;
        w_o_code = 1'b0;
        w_o_data = 1'b0;
        w_o_rreg = 1'b0;
        w_o_wreg = 1'b0;
        if (w_mcyc_n == 3'd1) begin
            w_o_s    = 2'b11;
            w_o_ale  = (w_ts_n == TS_T1);
            w_o_rd_n = !w_stb_n;
            w_o_code = (w_ts_n == TS_T3);
            w_o_rreg = (w_ts_n == TS_T4);
            w_o_wreg = ((w_ts_n == TS_T1) && w_rdterm_n) ||
                       ((w_ts_n == TS_T4) && w_m1_wb_n && !w_sh_n.go6) ||
                       ((w_ts_n == TS_T6) && w_m1_wb_n);
        end else if (w_mcyc_n >= 3'd2) begin
            w_o_s    = w_wr_n ? 2'b01 : 2'b10;
            w_o_iom  = w_sh_n.dio && (w_mcyc_n == 3'd3);
            w_o_ale  = (w_ts_n == TS_T1) && !w_idle_n;
            w_o_rd_n = !(w_stb_n && !w_idle_n && !w_wr_n);
            w_o_wr_n = !(w_stb_n && !w_idle_n && w_wr_n);
            w_o_data = (w_ts_n == TS_T3) && !w_idle_n && !w_wr_n;
            w_o_wreg = (w_ts_n == TS_T3) && w_sh_n.dad &&
                       ((w_mcyc_n == 3'd2) || (w_mcyc_n == 3'd3));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ale  <= 1'b0;
            r_rd_n <= 1'b1;
            r_wr_n <= 1'b1;
            r_iom  <= 1'b0;
            r_s    <= 2'b00;
            r_code <= 1'b0;
            r_data <= 1'b0;
            r_rreg <= 1'b0;
            r_wreg <= 1'b0;
        end else begin
            r_ale  <= w_o_ale;
            r_rd_n <= w_o_rd_n;
            r_wr_n <= w_o_wr_n;
            r_iom  <= w_o_iom;
            r_s    <= w_o_s;
            r_code <= w_o_code;
            r_data <= w_o_data;
            r_rreg <= w_o_rreg;
            r_wreg <= w_o_wreg;
        end
    end

    assign ale      = r_ale;
    assign rd_n     = r_rd_n;
    assign wr_n     = r_wr_n;
    assign iom      = r_iom;
    assign s1       = r_s[1];
    assign s0       = r_s[0];
    assign enb_code = r_code;
    assign enb_data = r_data;
    assign enb_rreg = r_rreg;
    assign enb_wreg = r_wreg;
    assign mcyc     = r_mcyc;
    assign tstate   = r_ts;
    assign halted   = r_halt;

endmodule

// File: tb/tb_mcycle_seq.sv
// Directed bench for mcycle_seq: walks instruction shapes clock by clock and compares
// {mcyc, tstate, bus pins, enables, halted} against hand-written expectations.
module tb_mcycle_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] chk_inst = '0;
    logic        cnd_chk = 1'b0;
    logic        ready = 1'b1;
    logic        enb_code, enb_data, enb_rreg, enb_wreg;
    logic        ale, rd_n, wr_n, iom, s1, s0, halted;
    logic [2:0]  mcyc, tstate;
    logic [16:0] obs;

    int n_chk  = 0;
    int n_fail = 0;

    // obs = {mcyc, tstate, ale, rd_n, wr_n, iom, s1, s0, code, data, rreg, wreg, halted}
    localparam logic [16:0] MASK_ALL = 17'h1FFFF;
    localparam logic [16:0] MASK_S   = 17'h1FF9F;
    localparam logic [16:0] MASK_W   = 17'h1FFFD;

    mcycle_seq #(.INSTSIZE(13), .INFO_CYC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .chk_inst (chk_inst),
        .cnd_chk  (cnd_chk),
        .ready    (ready),
        .enb_code (enb_code),
        .enb_data (enb_data),
        .enb_rreg (enb_rreg),
        .enb_wreg (enb_wreg),
        .ale      (ale),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .iom      (iom),
        .s1       (s1),
        .s0       (s0),
        .mcyc     (mcyc),
        .tstate   (tstate),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    assign obs = {mcyc, tstate, ale, rd_n, wr_n, iom, s1, s0,
                  enb_code, enb_data, enb_rreg, enb_wreg, halted};

    task automatic chk_eq(input string tag, input logic [16:0] got, input logic [16:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [16:0] ex(input int m, input int t, input bit a, input bit rdn,
                                       input bit wrn, input bit io, input bit [1:0] s,
                                       input bit code, input bit data, input bit rreg,
                                       input bit wreg, input bit hlt);
        logic [2:0] m3, t3;
        m3 = m[2:0];
        t3 = t[2:0];
        return {m3, t3, a, rdn, wrn, io, s, code, data, rreg, wreg, hlt};
    endfunction

    function automatic logic [16:0] m1s(input int t, input bit wreg);
        return ex(1, t, t == 1, !(t == 2 || t == 3 || t == 7), 1'b1, 1'b0, 2'b11,
                  t == 3, 1'b0, t == 4, wreg, 1'b0);
    endfunction

    function automatic logic [16:0] mks(input int k, input int t, input bit wr, input bit io);
        bit stb;
        stb = (t == 2 || t == 3 || t == 7);
        return ex(k, t, t == 1, !(stb && !wr), !(stb && wr), io, wr ? 2'b01 : 2'b10,
                  1'b0, (t == 3) && !wr, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [12:0] ci(input bit go6, input bit dad, input bit hlt,
                                       input bit dio, input logic [3:0] go,
                                       input logic [3:0] rw, input bit ccc);
        return {ccc, rw, go, dio, hlt, dad, go6};
    endfunction

    task automatic step(input string tag, input logic [16:0] want, input logic [16:0] msk);
        @(posedge clk);
        #1;
        chk_eq(tag, obs & msk, want & msk);
    endtask

    task automatic m1_run(input string tag, input bit wr_t1, input bit go6, input bit wr_last);
        step({tag, "_t1"}, m1s(1, wr_t1), MASK_ALL);
        step({tag, "_t2"}, m1s(2, 1'b0), MASK_ALL);
        step({tag, "_t3"}, m1s(3, 1'b0), MASK_ALL);
        step({tag, "_t4"}, m1s(4, wr_last && !go6), MASK_ALL);
        if (go6) begin
            step({tag, "_t5"}, m1s(5, 1'b0), MASK_ALL);
            step({tag, "_t6"}, m1s(6, wr_last), MASK_ALL);
        end
    endtask

    task automatic mk_run(input string tag, input int k, input bit wr, input bit io);
        for (int t = 1; t <= 3; t++)
            step($sformatf("%s_t%0d", tag, t), mks(k, t, wr, io), MASK_ALL);
    endtask

    task automatic idle_run(input string tag, input int k, input bit wreg);
        for (int t = 1; t <= 3; t++)
            step($sformatf("%s_t%0d", tag, t),
                 ex(k, t, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                    (t == 3) && wreg, 1'b0), MASK_S);
    endtask

    localparam logic [16:0] RST_V  = 17'b000_000_0110_00_0000_0;
    localparam logic [16:0] HALT_V = 17'b000_000_0110_00_0000_1;

    initial begin
        repeat (3) step("reset", RST_V, MASK_ALL);
        rst = 1'b0;

        // MOV B,C: 4-state M1 with writeback at T4
        chk_inst = ci(0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        m1_run("mov", 1'b0, 1'b0, 1'b1);

        // MVI M: M2 read, M3 write
        chk_inst = ci(0, 0, 0, 0, 4'b0011, 4'b0010, 0);
        m1_run("mvi", 1'b0, 1'b0, 1'b0);
        mk_run("mvi_m2", 2, 1'b0, 1'b0);
        mk_run("mvi_m3", 3, 1'b1, 1'b0);

        // Fetch stretched by three wait states
        chk_inst = ci(0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        step("wait_t1", m1s(1, 1'b0), MASK_ALL);
        ready = 1'b0;
        step("wait_t2", m1s(2, 1'b0), MASK_ALL);
        step("wait_tw1", m1s(7, 1'b0), MASK_ALL);
        step("wait_tw2", m1s(7, 1'b0), MASK_ALL);
        step("wait_tw3", m1s(7, 1'b0), MASK_ALL);
        ready = 1'b1;
        step("wait_t3", m1s(3, 1'b0), MASK_ALL);
        step("wait_t4", m1s(4, 1'b1), MASK_ALL);

        // OUT: M3 is the I/O write
        chk_inst = ci(0, 0, 0, 1, 4'b0011, 4'b0010, 0);
        m1_run("out", 1'b0, 1'b0, 1'b0);
        mk_run("out_m2", 2, 1'b0, 1'b0);
        mk_run("out_m3", 3, 1'b1, 1'b1);

        // CALL: 6-state M1, two reads, two writes
        chk_inst = ci(1, 0, 0, 0, 4'b1111, 4'b1100, 0);
        m1_run("call", 1'b0, 1'b1, 1'b0);
        mk_run("call_m2", 2, 1'b0, 1'b0);
        mk_run("call_m3", 3, 1'b0, 1'b0);
        mk_run("call_m4", 4, 1'b1, 1'b0);
        mk_run("call_m5", 5, 1'b1, 1'b0);

        // Conditional return, condition false then true
        cnd_chk  = 1'b1;
        chk_inst = ci(0, 0, 0, 0, 4'b0011, 4'b0000, 0);
        m1_run("rcc_skip", 1'b0, 1'b0, 1'b0);
        chk_inst = ci(0, 0, 0, 0, 4'b0011, 4'b0000, 1);
        m1_run("rcc_take", 1'b0, 1'b0, 1'b0);
        mk_run("rcc_m2", 2, 1'b0, 1'b0);
        mk_run("rcc_m3", 3, 1'b0, 1'b0);
        cnd_chk = 1'b0;

        // DAD: read-terminated predecessor gives writeback in T1; idle M2/M3 ignore ready
        chk_inst = ci(0, 1, 0, 0, 4'b0011, 4'b0000, 0);
        m1_run("dad", 1'b1, 1'b0, 1'b0);
        ready = 1'b0;
        idle_run("dad_m2", 2, 1'b1);
        idle_run("dad_m3", 3, 1'b1);
        ready = 1'b1;

        // HLT: idle M2 then halt until reset
        chk_inst = ci(0, 0, 1, 0, 4'b0000, 4'b0000, 0);
        step("hlt_t1", m1s(1, 1'b0), MASK_W);
        step("hlt_t2", m1s(2, 1'b0), MASK_ALL);
        step("hlt_t3", m1s(3, 1'b0), MASK_ALL);
        step("hlt_t4", m1s(4, 1'b0), MASK_W);
        idle_run("hlt_m2", 2, 1'b0);
        for (int i = 0; i < 20; i++) step($sformatf("halted_%0d", i), HALT_V, MASK_ALL);
        rst = 1'b1;
        step("hlt_rst", RST_V, MASK_ALL);
        rst = 1'b0;
        chk_inst = ci(0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        m1_run("after_hlt", 1'b0, 1'b0, 1'b1);

        // Reset during T2 aborts the fetch: no enb_code on that edge
        chk_inst = ci(0, 0, 0, 0, 4'b0011, 4'b0010, 0);
        step("abort_t1", m1s(1, 1'b0), MASK_ALL);
        step("abort_t2", m1s(2, 1'b0), MASK_ALL);
        rst = 1'b1;
        step("abort_rst", RST_V, MASK_ALL);
        rst = 1'b0;
        chk_inst = ci(0, 0, 0, 0, 4'b0000, 4'b0000, 0);
        m1_run("after_abort", 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
